fpmu_pipe: RTL and testbench
============================

// Module: fpmu_pipe
// PURPOSE
//  Parametrised, pipelined IEEE 754 binary floating-point multiplier, successor of the FP16 mantissa/exponent multiplier.
//  Performs full unpack, multiply, normalise, round-to-nearest-even and pack.
//  Handles zero/inf/NaN and uses a valid/ready handshake with backpressure.
//  Sits in the ALU datapath on the clk_alu domain. Throughput 1 result/cycle, latency 3 cycles.
// PARAMETERS
//  EXP_W  5   exponent field width; BIAS = 2**(EXP_W-1)-1
//  MAN_W  10  stored fraction width; hidden bit implicit; word width W = 1+EXP_W+MAN_W
// PORTS
//  clk_alu        in   1  clock, all state on rising edge
//  rst_alu_n      in   1  asynchronous, active-low reset
//  in_valid       in   1  operand pair valid
//  in_ready       out  1  block accepts the pair this cycle
//  operand_a      in   W  packed {sign, exp, frac}
//  operand_b      in   W  packed {sign, exp, frac}
//  out_valid      out  1  result valid
//  out_ready      in   1  consumer accepts the result
//  result         out  W  packed product
//  result_flags   out  4  {invalid, overflow, underflow, inexact} for this result (FPMU_FLAGS_EN only)
//  flags_sticky   out  4  OR-accumulated result_flags of handshaken results (FPMU_FLAGS_EN only)
//  flags_clr      in   1  synchronous clear of flags_sticky (FPMU_FLAGS_EN only)
// BEHAVIOUR
//  Reset: all stage valid bits 0 and out_valid 0; result and result_flags 0; flags_sticky 0.
//   in_ready is 1 after reset. Reset mid-operation discards in-flight data with no output.
//  Pipeline: S1 unpack/classify, sign xor, exp sum, (MAN_W+1)x(MAN_W+1) multiply.
//   S2 normalise and form guard/round/sticky. S3 round, range check, pack into output register.
//  Handshake: stage k loads when it is empty or its contents move on this cycle.
//   Output moves when out_valid & out_ready. in_ready = S1 empty | S1 moves.
//   Results are in order, with no loss or duplication. out_valid and result hold stable while out_ready=0.
//  Exponent arithmetic: signed EXP_W+2 bits; e = ea + eb - BIAS.
//   If product bit 2*MAN_W+1 is set: shift right 1 and e+1.
//  Rounding: RNE on guard/round/sticky. A mantissa carry-out renormalises and adds 1 to e.
//  Range: e >= 2**EXP_W-1 gives +/-inf with overflow and inexact set.
//   e <= 0 gives signed zero with underflow set, plus inexact if the product is nonzero (flush-to-zero).
//  Inputs: exp==0 is treated as signed zero; subnormal inputs flush to zero.
//   Any NaN input, or inf*zero, gives canonical qNaN {0, all-ones exp, 1 followed by zeros} with invalid set.
//   inf*finite-nonzero gives inf; zero*finite gives zero. Sign is always the xor of the operand signs, except for NaN.
//  Simultaneous flags_clr and a handshake: the clear wins, and that result's flags are dropped from flags_sticky.
// CONFIGURATION
//  FPMU_FLAGS_EN defined: result_flags travel alongside data through all stages. flags_sticky and flags_clr exist.
//  FPMU_FLAGS_EN undefined: the flag ports and flag pipeline registers are absent. Datapath results are identical.
// STRUCTURE
//  fpmu_pkg holds:
//   - class enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
//   - flag bit index constants FLG_INV/FLG_OVF/FLG_UNF/FLG_INX
//   - BIAS and canonical-NaN functions of EXP_W/MAN_W
//  Sub-module fpmu_round: combinational RNE rounder (mantissa, G/R/S in; rounded mantissa and carry out), instantiated in S3.
// TESTING (FP16 defaults)
//  1) 0x3C00 * 0x3C00 -> 0x3C00, out_valid exactly 3 cycles after accept, flags 0.
//     0x4000 * 0xC200 -> 0xC600.
//  2) 0x3C01 * 0x3C01 -> 0x3C02, inexact=1.
//     0x3C00 * 0x3BFF -> 0x3BFF, exact.
//  3) 0x7BFF * 0x7BFF -> 0x7C00, overflow=1 and inexact=1.
//     0x0400 * 0x0400 -> 0x0000, underflow=1.
//  4) 0x7C00 * 0x0000 -> 0x7E00, invalid=1.
//     0xFC00 * 0x4000 -> 0xFC00.
//     0x7E00 * 0x3C00 -> 0x7E00, invalid=1.
//  5) Stream 8 pairs with out_ready low for cycles 4-9: in_ready drops once S1-S3 and the output register are full.
//     All 8 results are delivered in order and unchanged while stalled. flags_sticky equals the OR of all flags; flags_clr clears it.
//  6) Assert rst_alu_n low with 3 pairs in flight: out_valid drops immediately and stays 0.
//     After release, a new pair yields only its own result.

Source files
------------

// File: rtl/fpmu_pkg.sv
// Shared types and helpers for the pipelined FP multiplier (fpmu_pipe).
package fpmu_pkg;

  typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

  localparam int NFLG    = 4;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN, right-aligned in 64 bits; callers truncate to W.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

  // Subnormals (exp==0, frac!=0) classify as zero: inputs flush to zero.
  function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                            input logic frac_nz);
    if (exp_zero) return FP_ZERO;
    if (exp_ones) return frac_nz ? FP_NAN : FP_INF;
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fpmu_round.sv
// Combinational round-to-nearest-even on a normalised mantissa with guard/round/sticky.
module fpmu_round
  import fpmu_pkg::*;
#(
  parameter int MAN_W = 10
) (
  input  logic [MAN_W:0]   mant,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [MAN_W-1:0] frac,
  output logic             carry
);
  logic inc;

  assign inc   = g & (r | s | mant[0]);
  // An all-ones mantissa wraps the fraction to zero; the caller bumps the exponent.
  assign carry = (&mant) & inc;
  assign frac  = mant[MAN_W-1:0] + MAN_W'(inc);

endmodule

// File: rtl/fpmu_pipe.sv
// 3-stage IEEE 754 multiplier with valid/ready backpressure, flush-to-zero, RNE.
// Optional exception flags and sticky accumulator under FPMU_FLAGS_EN.
module fpmu_pipe
  import fpmu_pkg::*;
#(
  parameter  int EXP_W = 5,
  parameter  int MAN_W = 10,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic            clk_alu,
  input  logic            rst_alu_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    operand_a,
  input  logic [W-1:0]    operand_b,
  output logic            out_valid,
  input  logic            out_ready,
`ifdef FPMU_FLAGS_EN
  output logic [NFLG-1:0] result_flags,
  output logic [NFLG-1:0] flags_sticky,
  input  logic            flags_clr,
`endif
  output logic [W-1:0]    result
);
  localparam int STAGES = 3;
  localparam int PW     = 2 * MAN_W + 2;
  localparam int EW     = EXP_W + 2;
  localparam logic [EW-1:0]    BIAS     = EW'(fp_bias(EXP_W));
  localparam logic [EW-1:0]    EMAX     = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [EXP_W-1:0] EXP_ONES = '1;

  typedef struct packed {
    fp_class_e     cls;
    logic          sign;
    logic [EW-1:0] e;
    logic [PW-1:0] prod;
  } s1_t;

  typedef struct packed {
    fp_class_e      cls;
    logic           sign;
    logic [EW-1:0]  e;
    logic [MAN_W:0] mant;
    logic           g;
    logic           r;
    logic           s;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  logic            en1, en2, en3;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;

  // A stage may load when empty or when its occupant leaves this cycle.
  assign en3       = ~vld_pipe[3] | out_ready;
  assign en2       = ~vld_pipe[2] | en3;
  assign en1       = ~vld_pipe[1] | en2;
  assign in_ready  = en1;
  assign out_valid = vld_pipe[3];

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  fp_class_e        ca, cb;

  assign ea = operand_a[W-2 -: EXP_W];
  assign eb = operand_b[W-2 -: EXP_W];
  assign fa = operand_a[MAN_W-1:0];
  assign fb = operand_b[MAN_W-1:0];
  assign ca = fp_classify(ea == '0, ea == EXP_ONES, fa != '0);
  assign cb = fp_classify(eb == '0, eb == EXP_ONES, fb != '0);

  always_comb begin
    s1_d      = '0;
    s1_d.sign = operand_a[W-1] ^ operand_b[W-1];
    s1_d.e    = {2'b00, ea} + {2'b00, eb} - BIAS;
    s1_d.prod = PW'({1'b1, fa}) * PW'({1'b1, fb});
    if (ca == FP_NAN || cb == FP_NAN || (ca == FP_INF && cb == FP_ZERO) ||
        (ca == FP_ZERO && cb == FP_INF))
      s1_d.cls = FP_NAN;
    else if (ca == FP_INF || cb == FP_INF)
      s1_d.cls = FP_INF;
    else if (ca == FP_ZERO || cb == FP_ZERO)
      s1_d.cls = FP_ZERO;
    else
      s1_d.cls = FP_NORM;
  end

  // Normalise so the leading one sits in the top bit; the dropped LSB joins sticky.
  logic [PW-1:0] np;

  always_comb begin
    np        = s1_q.prod[PW-1] ? s1_q.prod : {s1_q.prod[PW-2:0], 1'b0};
    s2_d.cls  = s1_q.cls;
    s2_d.sign = s1_q.sign;
    s2_d.e    = s1_q.e + EW'(s1_q.prod[PW-1]);
    s2_d.mant = np[PW-1:MAN_W+1];
    s2_d.g    = np[MAN_W];
    s2_d.r    = np[MAN_W-1];
    s2_d.s    = |np[MAN_W-2:0];
  end

  logic [MAN_W-1:0] frac_rnd;
  logic             carry;
  logic [EW-1:0]    e3;
  logic             ovf3, unf3;
  logic [W-1:0]     res_d;

  fpmu_round #(.MAN_W(MAN_W)) u_round (
    .mant  (s2_q.mant),
    .g     (s2_q.g),
    .r     (s2_q.r),
    .s     (s2_q.s),
    .frac  (frac_rnd),
    .carry (carry)
  );

  assign e3   = s2_q.e + EW'(carry);
  assign ovf3 = (s2_q.cls == FP_NORM) && ($signed(e3) >= $signed(EMAX));
  assign unf3 = (s2_q.cls == FP_NORM) && (e3[EW-1] || e3 == '0);

  always_comb begin
    res_d = '0;
    case (s2_q.cls)
      FP_NAN:  res_d = QNAN;
      FP_INF:  res_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      FP_ZERO: res_d = {s2_q.sign, {(W-1){1'b0}}};
      default: begin
        if (ovf3)      res_d = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
        else if (unf3) res_d = {s2_q.sign, {(W-1){1'b0}}};
        else           res_d = {s2_q.sign, e3[EXP_W-1:0], frac_rnd};
      end
    endcase
  end

  always_ff @(posedge clk_alu or negedge rst_alu_n) begin
    if (!rst_alu_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      result   <= '0;
    end else begin
      if (en1) vld_pipe[1] <= in_valid;
      if (en2) vld_pipe[2] <= vld_pipe[1];
      if (en3) vld_pipe[3] <= vld_pipe[2];
      if (en1 && in_valid)    s1_q   <= s1_d;
      if (en2 && vld_pipe[1]) s2_q   <= s2_d;
      if (en3 && vld_pipe[2]) result <= res_d;
    end
  end

`ifdef FPMU_FLAGS_EN
  logic [NFLG-1:0] flg_d;

  always_comb begin
    flg_d          = '0;
    flg_d[FLG_INV] = (s2_q.cls == FP_NAN);
    flg_d[FLG_OVF] = ovf3;
    flg_d[FLG_UNF] = unf3;
    flg_d[FLG_INX] = (s2_q.cls == FP_NORM) && (ovf3 | unf3 | s2_q.g | s2_q.r | s2_q.s);
  end

  // A clear coinciding with a handshake drops that result's flags.
  always_ff @(posedge clk_alu or negedge rst_alu_n) begin
    if (!rst_alu_n) begin
      result_flags <= '0;
      flags_sticky <= '0;
    end else begin
      if (en3 && vld_pipe[2]) result_flags <= flg_d;
      if (flags_clr)                   flags_sticky <= '0;
      else if (out_valid && out_ready) flags_sticky <= flags_sticky | result_flags;
    end
  end
`endif

endmodule

// File: tb/tb_fpmu_pipe.sv
// Bench for fpmu_pipe (FP16): directed table, random scoreboard, stall and reset sequences.
module tb_fpmu_pipe;
  logic        clk_alu = 1'b0;
  logic        rst_alu_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] operand_a, operand_b, result;
`ifdef FPMU_FLAGS_EN
  logic [3:0]  result_flags, flags_sticky;
  logic        flags_clr;
`endif

  fpmu_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk_alu      (clk_alu),
    .rst_alu_n    (rst_alu_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
`ifdef FPMU_FLAGS_EN
    .result_flags (result_flags),
    .flags_sticky (flags_sticky),
    .flags_clr    (flags_clr),
`endif
    .result       (result)
  );

  always #5 clk_alu = ~clk_alu;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: exact integer product, then RNE by remainder comparison, FTZ both ends.
  function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] r, output logic [3:0] f);
    int ea, eb, fa, fb, k, sh, x;
    longint p, q, rem, half;
    logic s;
    bit na, nb, ia, ib, za, zb;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    na = (ea == 31) && (fa != 0); nb = (eb == 31) && (fb != 0);
    ia = (ea == 31) && (fa == 0); ib = (eb == 31) && (fb == 0);
    za = (ea == 0);               zb = (eb == 0);
    f = 4'b0000;
    if (na || nb || (ia && zb) || (za && ib)) begin
      r = 16'h7E00; f = 4'b1000;
    end else if (ia || ib) begin
      r = {s, 15'h7C00};
    end else if (za || zb) begin
      r = {s, 15'h0000};
    end else begin
      p    = longint'(1024 + fa) * longint'(1024 + fb);
      k    = (p >= (longint'(1) << 21)) ? 21 : 20;
      sh   = k - 10;
      q    = p >> sh;
      rem  = p - (q << sh);
      half = longint'(1) << (sh - 1);
      x    = k + ea + eb - 50 + 15;
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 2048) begin q = 1024; x++; end
      if (x >= 31)     begin r = {s, 15'h7C00}; f = 4'b0101; end
      else if (x <= 0) begin r = {s, 15'h0000}; f = 4'b0011; end
      else begin
        r = {s, 5'(x), 10'(q - 1024)};
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [4:0] e;
    logic [9:0] fr;
    case ($urandom_range(0, 9))
      0:       e = 5'd0;
      1:       e = 5'd31;
      2:       e = 5'($urandom_range(1, 4));
      3:       e = 5'($urandom_range(27, 30));
      default: e = 5'($urandom_range(1, 30));
    endcase
    fr = ($urandom_range(0, 5) == 0) ? 10'h000 : 10'($urandom);
    return {1'($urandom), e, fr};
  endfunction

  // Scoreboard monitor: samples mid-low-phase, well away from the rising edge.
  logic [19:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_res;
  logic [3:0]  exp_sticky = 4'b0000;
  int          n_out = 0;
  logic [15:0] m_r;
  logic [3:0]  m_f;
  logic [19:0] m_e;

  always @(negedge clk_alu) begin
    #2;
    if (mon_en && rst_alu_n) begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_result", 32'(result), 32'(prev_res));
      end
      if (in_valid && in_ready) begin
        ref_mul(operand_a, operand_b, m_r, m_f);
        exp_q.push_back({m_f, m_r});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          m_e = exp_q.pop_front();
          check("stream_result", 32'(result), 32'(m_e[15:0]));
`ifdef FPMU_FLAGS_EN
          check("stream_flags", 32'(result_flags), 32'(m_e[19:16]));
          exp_sticky = flags_clr ? 4'b0000 : (exp_sticky | m_e[19:16]);
`endif
          n_out++;
        end
      end
`ifdef FPMU_FLAGS_EN
      else if (flags_clr) exp_sticky = 4'b0000;
`endif
      prev_stall = out_valid && !out_ready;
      prev_res   = result;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic [3:0] f, output int lat);
    @(negedge clk_alu);
    in_valid = 1'b1; operand_a = a; operand_b = b; out_ready = 1'b1;
    #3;
    check("accept_ready", 32'(in_ready), 32'd1);
    lat = 0;
    r   = 16'h0;
    f   = 4'h0;
    while (lat < 20) begin
      @(negedge clk_alu);
      in_valid = 1'b0;
      #3;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) check("wait_out_valid", 32'd0, 32'd1);
    r = result;
`ifdef FPMU_FLAGS_EN
    f = result_flags;
`endif
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t        tbl[10];
  logic [15:0] sa[8];
  logic [15:0] sb[8];
  logic [15:0] got_r;
  logic [3:0]  got_f;
  int          lat;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000};
    tbl[1] = '{16'h4000, 16'hC200, 16'hC600, 4'b0000};
    tbl[2] = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0001};
    tbl[3] = '{16'h3C00, 16'h3BFF, 16'h3BFF, 4'b0000};
    tbl[4] = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};
    tbl[5] = '{16'h0400, 16'h0400, 16'h0000, 4'b0011};
    tbl[6] = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
    tbl[7] = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
    tbl[8] = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b1000};
    tbl[9] = '{16'h8000, 16'h4000, 16'h8000, 4'b0000};
    sa = '{16'h3C00, 16'h3C01, 16'h4200, 16'h7BFF, 16'h0400, 16'h7C00, 16'h5555, 16'hC000};
    sb = '{16'h4000, 16'h3C01, 16'h4200, 16'h4000, 16'h3800, 16'h0000, 16'h2AAA, 16'h3C00};

    rst_alu_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    operand_a = '0; operand_b = '0;
`ifdef FPMU_FLAGS_EN
    flags_clr = 1'b0;
`endif
    repeat (3) @(negedge clk_alu);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FPMU_FLAGS_EN
    check("rst_flags", 32'({result_flags, flags_sticky}), 32'd0);
`endif
    rst_alu_n = 1'b1;

    // Directed vectors, one at a time, with latency measured per result.
    for (int i = 0; i < 10; i++) begin
      run_one(tbl[i].a, tbl[i].b, got_r, got_f, lat);
      check($sformatf("tbl%0d_result", i), 32'(got_r), 32'(tbl[i].r));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd3);
`ifdef FPMU_FLAGS_EN
      check($sformatf("tbl%0d_flags", i), 32'(got_f), 32'(tbl[i].f));
`endif
    end

`ifdef FPMU_FLAGS_EN
    @(negedge clk_alu); flags_clr = 1'b1;
    @(negedge clk_alu); flags_clr = 1'b0;
    #3;
    check("clr_after_table", 32'(flags_sticky), 32'd0);
    exp_sticky = 4'b0000;
`endif

    // Random traffic with random backpressure against the reference model.
    mon_en = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_alu);
      in_valid  = ($urandom_range(0, 3) != 0);
      operand_a = rnd_op();
      operand_b = rnd_op();
      out_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk_alu);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
      @(negedge clk_alu); #3;
    end
    check("rand_drain", 32'(exp_q.size()), 32'd0);

    // Eight back-to-back pairs with the consumer stalled for cycles 4-9.
    begin
      int j, cyc;
      logic saw_block;
      j = 0; cyc = 0; saw_block = 1'b0; n_out = 0;
      while ((j < 8 || exp_q.size() != 0 || out_valid) && cyc < 60) begin
        @(negedge clk_alu);
        in_valid = (j < 8);
        if (j < 8) begin operand_a = sa[j]; operand_b = sb[j]; end
        out_ready = !(cyc >= 4 && cyc <= 9);
        #3;
        if (in_valid && !in_ready) saw_block = 1'b1;
        if (in_valid && in_ready) j++;
        cyc++;
      end
      in_valid = 1'b0;
      check("stall_in_ready_dropped", 32'(saw_block), 32'd1);
      check("stall_delivered", 32'(n_out), 32'd8);
      check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    end
`ifdef FPMU_FLAGS_EN
    check("sticky_or", 32'(flags_sticky), 32'(exp_sticky));
    @(negedge clk_alu); flags_clr = 1'b1;
    @(negedge clk_alu); flags_clr = 1'b0;
    #3;
    check("sticky_clr", 32'(flags_sticky), 32'd0);
`endif

    // Reset with three pairs in flight and one result already presented.
    mon_en = 1'b0;
    exp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_alu);
      in_valid = 1'b1; operand_a = 16'h3C00 + 16'(i); operand_b = 16'h4000;
    end
    @(negedge clk_alu);
    in_valid = 1'b0;
    #2;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_alu_n = 1'b0;
    #1;
    check("rst_drop_valid", 32'(out_valid), 32'd0);
    begin
      logic any_v;
      any_v = 1'b0;
      repeat (2) begin @(negedge clk_alu); #3; any_v |= out_valid; end
      rst_alu_n = 1'b1;
`ifdef FPMU_FLAGS_EN
      exp_sticky = 4'b0000;
`endif
      out_ready = 1'b1;
      repeat (4) begin @(negedge clk_alu); #3; any_v |= out_valid; end
      check("post_rst_idle", 32'(any_v), 32'd0);
    end
    run_one(16'h4000, 16'h4200, got_r, got_f, lat);
    check("post_rst_result", 32'(got_r), 32'h4600);
    check("post_rst_latency", 32'(lat), 32'd3);
    begin
      int extra;
      extra = 0;
      repeat (6) begin @(negedge clk_alu); #3; if (out_valid) extra++; end
      check("post_rst_no_extra", 32'(extra), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
